ctrl_fsm: RTL and testbench

//  Multi-cycle controller for the execute datapath (operand/imm/write-back muxes, ALU, regfile).

---
 rtl/ctrl_fsm_pkg.sv | 66 ++++++
 rtl/ctrl_fsm_decoder.sv | 72 +++++++
 rtl/ctrl_fsm.sv | 145 ++++++++++++++
 tb/tb_ctrl_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm_pkg
// Purpose  : Shared definitions for the multi-cycle execute controller:
//            state encoding, instruction classes, opcode / ALU_1 sub-op
//            constants and datapath mux select codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_fsm_pkg;

  // Controller states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_PCUP   = 3'd6
  } state_e;

  // Instruction class selects the path taken after EXEC
  typedef enum logic [1:0] {
    CLS_ALU   = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } instr_class_e;

  // Primary opcodes (instruction[30:25])
  localparam logic [5:0] OP_ALU_1 = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b101000;
  localparam logic [5:0] OP_ORI   = 6'b101100;
  localparam logic [5:0] OP_MOVI  = 6'b100010;
  localparam logic [5:0] OP_LWI   = 6'b000010;
  localparam logic [5:0] OP_SWI   = 6'b001010;

  // ALU_1 sub-ops (instruction[4:0]) that need a non-default operand path
  localparam logic [4:0] SUB_SLLI     = 5'b01000;
  localparam logic [4:0] SUB_ROTRI    = 5'b01011;
  localparam logic [4:0] SUB_ADD_SLLI = 5'b11100;

  // ALU operand-2 mux
  localparam logic [2:0] SRC2_RB       = 3'b000;
  localparam logic [2:0] SRC2_IMM      = 3'b001;
  localparam logic [2:0] SRC2_IMM15_SH = 3'b010;
  localparam logic [2:0] SRC2_RB_SV    = 3'b011;
  localparam logic [2:0] SRC2_RT       = 3'b100;

  // Immediate extension mux
  localparam logic [1:0] IMM_5BIT_ZE  = 2'b00;
  localparam logic [1:0] IMM_15BIT_SE = 2'b01;
  localparam logic [1:0] IMM_15BIT_ZE = 2'b10;
  localparam logic [1:0] IMM_20BIT_SE = 2'b11;

  // Write-back data mux
  localparam logic [1:0] WR_ALU_OUT = 2'b00;
  localparam logic [1:0] WR_SRC2    = 2'b01;
  localparam logic [1:0] WR_MEM     = 2'b10;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[30:25];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_fsm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm_decoder
// Purpose  : Combinational opcode / sub-op decode into datapath selects,
//            instruction class and a legal flag.
// Ports    : opcode            in  6  primary opcode
//            sub_op            in  5  ALU_1 sub-operation
//            select_alu_src2   out 3  operand-2 mux select
//            select_imm_extend out 2  immediate extension select
//            select_write_reg  out 2  write-back mux select
//            instr_class       out 2  ALU / LOAD / STORE
//            legal             out 1  opcode supported
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm_decoder
  import ctrl_fsm_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [4:0]   sub_op,
  output logic [2:0]   select_alu_src2,
  output logic [1:0]   select_imm_extend,
  output logic [1:0]   select_write_reg,
  output instr_class_e instr_class,
  output logic         legal
);

  always_comb begin
    select_alu_src2   = SRC2_RB;
    select_imm_extend = IMM_5BIT_ZE;
    select_write_reg  = WR_ALU_OUT;
    instr_class       = CLS_ALU;
    legal             = 1'b1;
    case (opcode)
      OP_ALU_1: begin
        if (sub_op == SUB_SLLI || sub_op == SUB_ROTRI) begin
          select_alu_src2   = SRC2_IMM;
          select_imm_extend = IMM_5BIT_ZE;
        end else if (sub_op == SUB_ADD_SLLI) begin
          select_alu_src2 = SRC2_RB_SV;
        end
      end
      OP_ADDI: begin
        select_alu_src2   = SRC2_IMM;
        select_imm_extend = IMM_15BIT_SE;
      end
      OP_ORI: begin
        select_alu_src2   = SRC2_IMM;
        select_imm_extend = IMM_15BIT_ZE;
      end
      OP_MOVI: begin
        select_alu_src2   = SRC2_IMM;
        select_imm_extend = IMM_20BIT_SE;
        select_write_reg  = WR_SRC2;
      end
      OP_LWI: begin
        select_alu_src2   = SRC2_IMM15_SH;
        select_imm_extend = IMM_15BIT_SE;
        select_write_reg  = WR_MEM;
        instr_class       = CLS_LOAD;
      end
      OP_SWI: begin
        // Address comes from imm15<<2; store data is routed from rt by the datapath
        select_alu_src2   = SRC2_IMM15_SH;
        select_imm_extend = IMM_15BIT_SE;
        instr_class       = CLS_STORE;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_fsm
// Purpose  : Multi-cycle controller sequencing FETCH/DECODE/EXEC/MEM/WB/PCUP
//            with req/ack handshakes to instruction and data memory.
// Ports    : clock, reset (async, active-high)
//            instruction in 32, im_ack / dm_ack in 1
//            im_req, dm_req, dm_write, ir_enable, reg_write, pc_enable,
//            illegal out 1; select_alu_src2 out 3; select_imm_extend,
//            select_write_reg out 2
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] instruction,
  input  logic                 im_ack,
  input  logic                 dm_ack,
  output logic                 im_req,
  output logic                 dm_req,
  output logic                 dm_write,
  output logic                 ir_enable,
  output logic                 reg_write,
  output logic                 pc_enable,
  output logic                 illegal,
  output logic [2:0]           select_alu_src2,
  output logic [1:0]           select_imm_extend,
  output logic [1:0]           select_write_reg
);

  state_e       state_q, state_d;
  instr_class_e cls_q, cls_d;
  logic [2:0]   src2_q, src2_d;
  logic [1:0]   imm_q, imm_d;
  logic [1:0]   wr_q, wr_d;
  logic         illegal_q, illegal_d;
  logic         im_req_q, im_req_d;
  logic         dm_req_q, dm_req_d;
  logic         dm_write_q, dm_write_d;
  logic         reg_write_q, reg_write_d;
  logic         pc_enable_q, pc_enable_d;

  logic [2:0]   dec_src2;
  logic [1:0]   dec_imm;
  logic [1:0]   dec_wr;
  instr_class_e dec_class;
  logic         dec_legal;

  // Only opcode and sub-op fields steer control; remaining bits feed the datapath
  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction;

  ctrl_fsm_decoder u_decoder (
    .opcode            (opcode_of(instruction[31:0])),
    .sub_op            (instruction[4:0]),
    .select_alu_src2   (dec_src2),
    .select_imm_extend (dec_imm),
    .select_write_reg  (dec_wr),
    .instr_class       (dec_class),
    .legal             (dec_legal)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    src2_d    = src2_q;
    imm_d     = imm_q;
    wr_d      = wr_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (im_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        // Selects are captured here so they stay stable until the next DECODE
        cls_d  = dec_class;
        src2_d = dec_src2;
        imm_d  = dec_imm;
        wr_d   = dec_wr;
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_PCUP;
        end
      end
      ST_EXEC:  state_d = (cls_q == CLS_ALU) ? ST_WB : ST_MEM;
      ST_MEM:   if (dm_ack) state_d = (cls_q == CLS_LOAD) ? ST_WB : ST_PCUP;
      ST_WB:    state_d = ST_PCUP;
      ST_PCUP:  state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
    // Outputs are registered copies of what the next state requires
    im_req_d    = (state_d == ST_FETCH);
    dm_req_d    = (state_d == ST_MEM);
    dm_write_d  = (state_d == ST_MEM) && (cls_d == CLS_STORE);
    reg_write_d = (state_d == ST_WB);
    pc_enable_d = (state_d == ST_PCUP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cls_q       <= CLS_ALU;
      src2_q      <= 3'b000;
      imm_q       <= 2'b00;
      wr_q        <= 2'b00;
      illegal_q   <= 1'b0;
      im_req_q    <= 1'b0;
      dm_req_q    <= 1'b0;
      dm_write_q  <= 1'b0;
      reg_write_q <= 1'b0;
      pc_enable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      src2_q      <= src2_d;
      imm_q       <= imm_d;
      wr_q        <= wr_d;
      illegal_q   <= illegal_d;
      im_req_q    <= im_req_d;
      dm_req_q    <= dm_req_d;
      dm_write_q  <= dm_write_d;
      reg_write_q <= reg_write_d;
      pc_enable_q <= pc_enable_d;
    end
  end

  // IR load coincides with the acknowledged fetch cycle
  assign ir_enable         = (state_q == ST_FETCH) && im_ack;
  assign im_req            = im_req_q;
  assign dm_req            = dm_req_q;
  assign dm_write          = dm_write_q;
  assign reg_write         = reg_write_q;
  assign pc_enable         = pc_enable_q;
  assign illegal           = illegal_q;
  assign select_alu_src2   = src2_q;
  assign select_imm_extend = imm_q;
  assign select_write_reg  = wr_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_fsm
// Purpose  : Self-checking bench for ctrl_fsm: directed scenarios plus
//            randomized instruction streams with random ack latencies and
//            spurious acks, compared cycle by cycle against an
//            instruction-level timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_fsm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        im_ack = 1'b0;
  logic        dm_ack = 1'b0;
  logic        im_req, dm_req, dm_write, ir_enable, reg_write, pc_enable, illegal;
  logic [2:0]  select_alu_src2;
  logic [1:0]  select_imm_extend, select_write_reg;

  int checks = 0;
  int failures = 0;
  bit ill_model = 1'b0;
  int cyc = 0;

  always #5 clock = ~clock;

  ctrl_fsm #(.DATA_SIZE(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .instruction       (instruction),
    .im_ack            (im_ack),
    .dm_ack            (dm_ack),
    .im_req            (im_req),
    .dm_req            (dm_req),
    .dm_write          (dm_write),
    .ir_enable         (ir_enable),
    .reg_write         (reg_write),
    .pc_enable         (pc_enable),
    .illegal           (illegal),
    .select_alu_src2   (select_alu_src2),
    .select_imm_extend (select_imm_extend),
    .select_write_reg  (select_write_reg)
  );

  // One cycle of expected behaviour: inputs to apply and outputs to expect
  typedef struct {
    bit       im_ack;
    bit       dm_ack;
    bit [6:0] exp;     // {im_req, ir_enable, dm_req, dm_write, reg_write, pc_enable, illegal}
    bit       sel_chk;
    bit       is_mem;
  } cyc_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [6:0] outs_now();
    return {im_req, ir_enable, dm_req, dm_write, reg_write, pc_enable, illegal};
  endfunction

  // Reference decode straight from the instruction-set table
  function automatic void ref_decode(input logic [31:0] ins, output bit legal, output int kind,
                                     output logic [2:0] src2, output logic [1:0] imm,
                                     output logic [1:0] wr);
    logic [5:0] op;
    logic [4:0] sub;
    op = ins[30:25];
    sub = ins[4:0];
    legal = 1'b1; kind = 0; src2 = 3'd0; imm = 2'd0; wr = 2'd0;
    case (op)
      6'b100000: begin
        if (sub == 5'b01000 || sub == 5'b01011) src2 = 3'd1;
        else if (sub == 5'b11100) src2 = 3'd3;
      end
      6'b101000: begin imm = 2'd1; src2 = 3'd1; end
      6'b101100: begin imm = 2'd2; src2 = 3'd1; end
      6'b100010: begin imm = 2'd3; src2 = 3'd1; wr = 2'd1; end
      6'b000010: begin imm = 2'd1; src2 = 3'd2; wr = 2'd2; kind = 1; end
      6'b001010: begin imm = 2'd1; src2 = 3'd2; kind = 2; end
      default:   legal = 1'b0;
    endcase
  endfunction

  function automatic bit spur();
    return ($urandom_range(0, 2) == 0);
  endfunction

  // Run one instruction with fetch wait di and data wait dd; optionally
  // assert reset during the first MEM cycle instead of completing it.
  task automatic run_instr(input logic [31:0] ins, input int di, input int dd, input bit rst_in_mem);
    cyc_t q[$];
    cyc_t e;
    bit legal;
    int kind;
    logic [2:0] src2;
    logic [1:0] imm, wr;
    bit ill_after;
    ref_decode(ins, legal, kind, src2, imm, wr);
    ill_after = ill_model | ~legal;
    for (int k = 0; k <= di; k++) begin
      e = '{im_ack: (k == di), dm_ack: spur(), exp: {1'b1, k == di, 5'b0} | 7'(ill_model),
            sel_chk: 1'b0, is_mem: 1'b0};
      q.push_back(e);
    end
    q.push_back('{spur(), spur(), 7'(ill_model), 1'b0, 1'b0});                 // DECODE
    if (!legal) begin
      q.push_back('{spur(), spur(), 7'b0000010 | 7'(ill_after), 1'b0, 1'b0});  // PCUP
    end else begin
      q.push_back('{spur(), spur(), 7'(ill_after), 1'b1, 1'b0});               // EXEC
      if (kind != 0)
        for (int k = 0; k <= dd; k++)
          q.push_back('{spur(), (k == dd), {2'b00, 1'b1, kind == 2, 3'b000} | 7'(ill_after),
                        1'b0, 1'b1});
      if (kind != 2) q.push_back('{spur(), spur(), 7'b0000100 | 7'(ill_after), 1'b0, 1'b0});
      q.push_back('{spur(), spur(), 7'b0000010 | 7'(ill_after), 1'b1, 1'b0});  // PCUP
    end
    instruction = ins;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clock);
      cyc++;
      #1;
      im_ack = e.im_ack;
      dm_ack = e.dm_ack;
      #1;
      check($sformatf("outs c%0d op%0h", cyc, ins[30:25]), 32'(outs_now()), 32'(e.exp));
      if (e.sel_chk) begin
        check($sformatf("src2 c%0d", cyc), 32'(select_alu_src2), 32'(src2));
        check($sformatf("imm c%0d", cyc), 32'(select_imm_extend), 32'(imm));
        check($sformatf("wr c%0d", cyc), 32'(select_write_reg), 32'(wr));
      end
      if (e.is_mem && rst_in_mem) begin
        im_ack = 1'b0;
        dm_ack = 1'b0;
        #1 reset = 1'b1;
        #1 check("rst_mid_mem async", 32'(outs_now()), 32'h0);
        @(posedge clock);
        #1 check("rst_mid_mem held", 32'(outs_now()), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        #1 check("rst_mid_mem idle", 32'(outs_now()), 32'h0);
        ill_model = 1'b0;
        return;
      end
    end
    im_ack = 1'b0;
    dm_ack = 1'b0;
    ill_model = ill_after;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [24:0] rest);
    logic [31:0] v;
    v = {1'b0, op, rest};
    return v;
  endfunction

  initial begin
    logic [31:0] ins;
    logic [5:0] ops [6];
    ops[0] = 6'b100000; ops[1] = 6'b101000; ops[2] = 6'b101100;
    ops[3] = 6'b100010; ops[4] = 6'b000010; ops[5] = 6'b001010;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset outs", 32'(outs_now()), 32'h0);
    check("reset selects", 32'({select_alu_src2, select_imm_extend, select_write_reg}), 32'h0);
    reset = 1'b0;
    #1 check("idle outs", 32'(outs_now()), 32'h0);

    // ADDI with max imm15, zero-wait fetch
    run_instr(mk(6'b101000, {10'h0, 15'h7FFF}), 0, 0, 1'b0);
    // LWI with dm_ack three cycles late
    run_instr(mk(6'b000010, 25'h0123), 0, 3, 1'b0);
    // SWI
    run_instr(mk(6'b001010, 25'h0456), 1, 0, 1'b0);
    // Illegal opcode, then MOVI keeps the sticky flag
    run_instr(mk(6'b111111, 25'h0), 0, 0, 1'b0);
    run_instr(mk(6'b100010, 25'hFFFFF), 2, 0, 1'b0);
    // ALU_1 variants
    run_instr(mk(6'b100000, 25'h00008), 0, 0, 1'b0);
    run_instr(mk(6'b100000, 25'h0001C), 0, 0, 1'b0);
    run_instr(mk(6'b101100, 25'h1234), 0, 0, 1'b0);
    // Reset during an outstanding data request clears everything incl. illegal
    run_instr(mk(6'b000010, 25'h0), 0, 5, 1'b1);

    for (int n = 0; n < 60; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[30:25] = ops[$urandom_range(0, 5)];
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
